// File: rtl/inst_cache.sv
// inst_cache: direct-mapped instruction cache, responder end of the fetch interface.
//
// Each request accepted on fetch_enable/cache_pc is answered by exactly one
// cache_valid pulse with cache_inst. On a miss, a whole line is filled from the
// memory controller one word at a time over mem_req/mem_addr/mem_valid/mem_data.
// hit_valid/hit_inst form a combinational hit probe of cache_pc for the branch
// predictor.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   rdy                  global enable; all state holds while low
//   flush                aborts the outstanding request (mispredict recovery)
//   fetch_enable         request the instruction at cache_pc
//   cache_pc[31:0]       request byte address (bits [1:0] ignored)
//   cache_valid          one-cycle response pulse
//   cache_inst[31:0]     response word
//   hit_valid            cache_pc hits a valid line (combinational)
//   hit_inst[31:0]       word at cache_pc, 0 on miss (combinational)
//   mem_req              line fill in progress
//   mem_addr[31:0]       line-aligned fill address
//   mem_valid            one fill word delivered, ascending order
//   mem_data[31:0]       fill word
//
// Build option: define ICACHE_CRITICAL_WORD_EN for early restart, where the
// requested word is returned the cycle after it arrives during the fill.

module inst_cache #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned SET_BITS   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        fetch_enable,
    input  logic [31:0] cache_pc,
    output logic        cache_valid,
    output logic [31:0] cache_inst,
    output logic        hit_valid,
    output logic [31:0] hit_inst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data
);

    localparam int unsigned OFF_BITS  = $clog2(LINE_WORDS);
    localparam int unsigned IDX_LO    = OFF_BITS + 2;
    localparam int unsigned TAG_LO    = IDX_LO + SET_BITS;
    localparam int unsigned TAG_BITS  = 32 - TAG_LO;
    localparam int unsigned NUM_LINES = 1 << SET_BITS;
    localparam logic [OFF_BITS-1:0] LAST_WORD = OFF_BITS'(LINE_WORDS - 1);
    localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

    typedef enum logic [1:0] {IDLE, RESP, FILL} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [31:0]          r_data [NUM_LINES*LINE_WORDS];
    logic [TAG_BITS-1:0]  r_tag  [NUM_LINES];
    logic [NUM_LINES-1:0] r_line_valid;

    // Fields of the request being filled
    logic [OFF_BITS-1:0]  r_rq_off;
    logic [SET_BITS-1:0]  r_rq_idx;
    logic [TAG_BITS-1:0]  r_rq_tag;
    logic [OFF_BITS-1:0]  r_cnt;

    logic [OFF_BITS-1:0]  w_pc_off;
    logic [SET_BITS-1:0]  w_pc_idx;
    logic [TAG_BITS-1:0]  w_pc_tag;
    logic                 w_fill_beat;
    logic                 w_fill_last;
    logic [31:0]          w_req_word;

    logic                 w_cache_valid_n;
    logic [31:0]          w_cache_inst_n;
    logic                 w_mem_req_n;
    logic [31:0]          w_mem_addr_n;
    logic [OFF_BITS-1:0]  w_cnt_n;
    logic                 w_capture;
    logic                 w_data_we;
    logic                 w_line_set;
    logic                 w_line_clr;

    assign w_pc_off = cache_pc[IDX_LO-1:2];
    assign w_pc_idx = cache_pc[TAG_LO-1:IDX_LO];
    assign w_pc_tag = cache_pc[31:TAG_LO];

    assign hit_valid = r_line_valid[w_pc_idx] && (r_tag[w_pc_idx] == w_pc_tag);
    assign hit_inst  = hit_valid ? r_data[{w_pc_idx, w_pc_off}] : '0;

    assign w_fill_beat = (r_state == FILL) && mem_valid;
    assign w_fill_last = w_fill_beat && (r_cnt == LAST_WORD);
    // The requested word is either arriving now or was written on an earlier beat
    assign w_req_word  = (r_rq_off == r_cnt) ? mem_data : r_data[{r_rq_idx, r_rq_off}];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (rdy) begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (fetch_enable) begin
                        w_state_next = hit_valid ? RESP : FILL;
                    end
                end
                RESP: w_state_next = IDLE;
                FILL: begin
                    if (w_fill_last) begin
`ifdef ICACHE_CRITICAL_WORD_EN
                        // An earlier beat already answered unless the requested
                        // word is the last one; then the pulse goes out from RESP
                        // so the fetcher's pc update cannot be re-accepted.
                        w_state_next = (r_rq_off == LAST_WORD) ? RESP : IDLE;
`else
                        w_state_next = RESP;
`endif
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Output / datapath next-value logic
    always_comb begin
        w_cache_valid_n = 1'b0;
        w_cache_inst_n  = cache_inst;
        w_mem_req_n     = mem_req;
        w_mem_addr_n    = mem_addr;
        w_cnt_n         = r_cnt;
        w_capture       = 1'b0;
        w_data_we       = 1'b0;
        w_line_set      = 1'b0;
        w_line_clr      = 1'b0;
        if (flush) begin
            w_mem_req_n = 1'b0;
            w_cnt_n     = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (fetch_enable) begin
                        if (hit_valid) begin
                            w_cache_valid_n = 1'b1;
                            w_cache_inst_n  = hit_inst;
                        end else begin
                            w_capture    = 1'b1;
                            w_line_clr   = 1'b1;
                            w_mem_req_n  = 1'b1;
                            w_mem_addr_n = cache_pc & ~LINE_MASK;
                            w_cnt_n      = '0;
                        end
                    end
                end
                FILL: begin
                    if (w_fill_beat) begin
                        w_data_we = 1'b1;
                        w_cnt_n   = r_cnt + OFF_BITS'(1);
`ifdef ICACHE_CRITICAL_WORD_EN
                        if (r_cnt == r_rq_off) begin
                            w_cache_valid_n = 1'b1;
                            w_cache_inst_n  = mem_data;
                        end
`endif
                        if (w_fill_last) begin
                            w_line_set  = 1'b1;
                            w_mem_req_n = 1'b0;
`ifndef ICACHE_CRITICAL_WORD_EN
                            w_cache_valid_n = 1'b1;
                            w_cache_inst_n  = w_req_word;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid  <= 1'b0;
            cache_inst   <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            r_cnt        <= '0;
            r_rq_off     <= '0;
            r_rq_idx     <= '0;
            r_rq_tag     <= '0;
            r_line_valid <= '0;
        end else if (rdy) begin
            cache_valid <= w_cache_valid_n;
            cache_inst  <= w_cache_inst_n;
            mem_req     <= w_mem_req_n;
            mem_addr    <= w_mem_addr_n;
            r_cnt       <= w_cnt_n;
            if (w_capture) begin
                r_rq_off <= w_pc_off;
                r_rq_idx <= w_pc_idx;
                r_rq_tag <= w_pc_tag;
            end
            if (w_line_clr) r_line_valid[w_pc_idx] <= 1'b0;
            if (w_line_set) r_line_valid[r_rq_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            if (w_data_we)  r_data[{r_rq_idx, r_cnt}] <= mem_data;
            if (w_line_set) r_tag[r_rq_idx]           <= r_rq_tag;
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: self-checking bench for inst_cache (default geometry 4 words x 64 lines).
// Expected responses are queued when a request is accepted and compared when the
// response pulse is consumed (cache_valid high at an edge with rdy high).
// Works with or without ICACHE_CRITICAL_WORD_EN defined.

module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, fetch_enable, mem_valid;
    logic [31:0] cache_pc, mem_data;
    logic        cache_valid, hit_valid, mem_req;
    logic [31:0] cache_inst, hit_inst, mem_addr;

    always #5 clk = ~clk;

    inst_cache #(.LINE_WORDS(4), .SET_BITS(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .fetch_enable(fetch_enable), .cache_pc(cache_pc),
        .cache_valid(cache_valid), .cache_inst(cache_inst),
        .hit_valid(hit_valid), .hit_inst(hit_inst),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_data(mem_data)
    );

`ifdef ICACHE_CRITICAL_WORD_EN
    localparam bit CRIT = 1'b1;
`else
    localparam bit CRIT = 1'b0;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] pc;
        logic        fetch;
        logic        exp_hit;
        logic [31:0] exp_inst;
    } vec_t;
    vec_t tbl[8];

    // Memory image: 0x0..0xC hold 0x13, 0x100093, 0x200113, 0x300193, continuing linearly
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h13 + (a >> 2) * 32'h0010_0080;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; a pulse seen with rdy high at the edge is consumed and scored
    task automatic step();
        logic        v;
        logic        r;
        logic [31:0] d;
        v = cache_valid;
        r = rdy;
        d = cache_inst;
        @(posedge clk);
        #1;
        if (v === 1'b1 && r === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got inst %h expected no response", d);
            end else begin
                chk("resp_inst", d, exp_q.pop_front());
            end
        end
    endtask

    task automatic wait_resp(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        chk("resp_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_miss(input logic [31:0] pc);
        logic [31:0] base;
        int          off;
        base = pc & ~32'hF;
        off  = int'(pc[3:2]);
        cache_pc     = pc;
        fetch_enable = 1'b1;
        #1;
        chk("miss_probe", 32'(hit_valid), 32'd0);
        exp_q.push_back(mem_word(base + 32'(off * 4)));
        step();
        fetch_enable = 1'b0;
        chk("mem_req_on", 32'(mem_req), 32'd1);
        chk("mem_addr", mem_addr, base);
        chk("fill_start_valid", 32'(cache_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            mem_valid = 1'b1;
            mem_data  = mem_word(base + 32'(k * 4));
            step();
            mem_valid = 1'b0;
            chk("fill_valid", 32'(cache_valid), 32'((CRIT && k == off) || (!CRIT && k == 3)));
            chk("fill_req", 32'(mem_req), 32'(k < 3));
        end
        mem_data = '0;
        wait_resp(4);
        chk("after_fill_valid", 32'(cache_valid), 32'd0);
    endtask

    task automatic hit_fetch(input logic [31:0] pc, input logic [31:0] exp);
        cache_pc     = pc;
        fetch_enable = 1'b1;
        #1;
        chk("hit_probe_valid", 32'(hit_valid), 32'd1);
        chk("hit_probe_inst", hit_inst, exp);
        exp_q.push_back(exp);
        step();
        fetch_enable = 1'b0;
        chk("hit_resp_valid", 32'(cache_valid), 32'd1);
        chk("hit_no_mem_req", 32'(mem_req), 32'd0);
        wait_resp(4);
        chk("hit_pulse_end", 32'(cache_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h0000_0000, 1'b1, 1'b1, 32'h0000_0013};
        tbl[1] = '{32'h0000_0004, 1'b0, 1'b1, 32'h0010_0093};
        tbl[2] = '{32'h0000_0008, 1'b1, 1'b1, 32'h0020_0113};
        tbl[3] = '{32'h0000_000C, 1'b0, 1'b1, 32'h0030_0193};
        tbl[4] = '{32'h0000_0003, 1'b0, 1'b1, 32'h0000_0013};
        tbl[5] = '{32'h0000_0010, 1'b0, 1'b0, 32'h0000_0000};
        tbl[6] = '{32'h0000_0400, 1'b0, 1'b0, 32'h0000_0000};
        tbl[7] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000};

        rst = 1'b1; rdy = 1'b1; flush = 1'b0; fetch_enable = 1'b0;
        mem_valid = 1'b0; mem_data = '0; cache_pc = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_cache_valid", 32'(cache_valid), 32'd0);
        chk("rst_cache_inst", cache_inst, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_hit_valid", 32'(hit_valid), 32'd0);
        step();

        // Cold miss on line 0
        do_miss(32'h0);

        // Table of probes / hit fetches against line 0
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].fetch) begin
                hit_fetch(tbl[i].pc, tbl[i].exp_inst);
            end else begin
                cache_pc     = tbl[i].pc;
                fetch_enable = 1'b0;
                #1;
                chk("tbl_hit_valid", 32'(hit_valid), 32'(tbl[i].exp_hit));
                chk("tbl_hit_inst", hit_inst, tbl[i].exp_inst);
                step();
            end
        end

        // Conflict eviction of index 0, then refetch of 0x0 misses again
        do_miss(32'h400);
        hit_fetch(32'h404, mem_word(32'h404));
        do_miss(32'h0);

        // Top of address space and a mid-line requested word
        do_miss(32'hFFFF_FFFC);
        hit_fetch(32'hFFFF_FFF0, mem_word(32'hFFFF_FFF0));
        do_miss(32'h48);

        // Flush mid-fill; a request held during the flush cycle is not accepted
        cache_pc     = 32'h20;
        fetch_enable = 1'b1;
        if (CRIT) exp_q.push_back(mem_word(32'h20));
        step();
        fetch_enable = 1'b0;
        chk("flush_fill_req", 32'(mem_req), 32'd1);
        chk("flush_fill_addr", mem_addr, 32'h20);
        for (int k = 0; k < 2; k++) begin
            mem_valid = 1'b1;
            mem_data  = mem_word(32'h20 + 32'(k * 4));
            step();
        end
        mem_valid    = 1'b0;
        flush        = 1'b1;
        fetch_enable = 1'b1;
        cache_pc     = 32'h0;
        step();
        flush        = 1'b0;
        fetch_enable = 1'b0;
        chk("flush_mem_req", 32'(mem_req), 32'd0);
        chk("flush_valid", 32'(cache_valid), 32'd0);
        mem_valid = 1'b1;
        mem_data  = 32'hDEAD_BEEF;
        step();
        mem_valid = 1'b0;
        chk("idle_stray_valid", 32'(cache_valid), 32'd0);
        chk("idle_stray_req", 32'(mem_req), 32'd0);
        cache_pc = 32'h20;
        #1;
        chk("partial_line_hit", 32'(hit_valid), 32'd0);
        chk("flush_queue", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        step();
        do_miss(32'h20);
        hit_fetch(32'h24, mem_word(32'h24));

        // rdy low while the response is pending holds it for one consumption
        cache_pc     = 32'h8;
        fetch_enable = 1'b1;
        exp_q.push_back(32'h0020_0113);
        step();
        fetch_enable = 1'b0;
        rdy          = 1'b0;
        cache_pc     = 32'h4;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rdy_hold_valid", 32'(cache_valid), 32'd1);
            chk("rdy_hold_inst", cache_inst, 32'h0020_0113);
        end
        rdy = 1'b1;
        step();
        chk("rdy_resume_valid", 32'(cache_valid), 32'd0);
        chk("rdy_queue", 32'(exp_q.size()), 32'd0);
        step();
        step();
        chk("rdy_no_repeat", 32'(cache_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
